// File: rtl/exe_pkg.sv
// exe_pkg: shared types, arbitration modes and ROB age helpers for the EXE result path
package exe_pkg;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR = 1;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_IDX_W = 4;
  localparam int DEF_RD_W = 7;
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_IDX_W-1:0] rob_idx;
    logic [DEF_RD_W-1:0] rd;
  } result_t;
  typedef enum logic {SLOT_EMPTY, SLOT_HELD} slot_state_t;
  function automatic logic [15:0] rob_age(input logic [15:0] idx, input logic [15:0] head, input logic [15:0] mask);
    return (idx - head) & mask;
  endfunction
  function automatic logic is_younger(input logic [15:0] idx, input logic [15:0] ref_idx, input logic [15:0] head, input logic [15:0] mask);
    return rob_age(idx, head, mask) > rob_age(ref_idx, head, mask);
  endfunction
endpackage

// File: rtl/exe_result_arbiter_slot.sv
// fu_skid_slot: one-entry skid slot holding a functional-unit result that lost arbitration
module fu_skid_slot
  import exe_pkg::*;
#(
  parameter int W = 43
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_payload,
  input  logic         grant,
  input  logic         kill,
  output logic         ready,
  output logic         cand_valid,
  output logic [W-1:0] cand_payload
);
  slot_state_t state, state_nx;
  logic [W-1:0] payload;
  // capture when the live result neither wins nor dies; drain a held result on grant or kill
  always_comb begin
    state_nx = (state == SLOT_HELD) ? ((grant || kill) ? SLOT_EMPTY : SLOT_HELD)
                                    : ((in_valid && !grant && !kill) ? SLOT_HELD : SLOT_EMPTY);
  end
  // state and payload registers; payload only loads while empty so held data is never overwritten
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SLOT_EMPTY;
      payload <= '0;
    end else begin
      state <= state_nx;
      if (state == SLOT_EMPTY && in_valid) payload <= in_payload;
    end
  end
  assign ready = (state == SLOT_EMPTY);
  assign cand_valid = (state == SLOT_HELD) || in_valid;
  assign cand_payload = (state == SLOT_HELD) ? payload : in_payload;
endmodule

// File: rtl/exe_result_arbiter.sv
// exe_result_arbiter: collects FU results through skid slots and picks one winner per cycle for forward and writeback
module exe_result_arbiter
  import exe_pkg::*;
#(
  parameter int N_FU = 8,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W = DEF_RD_W,
  parameter int ROB_LEN = 16,
  parameter int ARB_MODE = ARB_RR,
  localparam int IDX_W = $clog2(ROB_LEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_FU-1:0]        fu_valid,
  input  logic [N_FU*DATA_W-1:0] fu_data,
  input  logic [N_FU*IDX_W-1:0]  fu_rob_idx,
  input  logic [N_FU*RD_W-1:0]   fu_rd,
  output logic [N_FU-1:0]        fu_ready,
  input  logic [IDX_W-1:0]       rob_head,
  input  logic                   flush_valid,
  input  logic [IDX_W-1:0]       flush_rob_idx,
  output logic                   fwd_valid,
  output logic [DATA_W-1:0]      fwd_data,
  output logic [IDX_W-1:0]       fwd_rob_idx,
  output logic [RD_W-1:0]        fwd_rd,
  output logic                   wb_valid,
  output logic [DATA_W-1:0]      wb_data,
  output logic [IDX_W-1:0]       wb_rob_idx,
  output logic [RD_W-1:0]        wb_rd,
  output logic [N_FU-1:0]        grant_oh
);
  localparam int PW = $clog2(N_FU);
  localparam int P_W = DATA_W + IDX_W + RD_W;
  logic [P_W-1:0] cand_pl [N_FU];
  logic [P_W-1:0] fwd_pl;
  logic [N_FU-1:0] cand_valid, kill, eligible, masked;
  logic [PW-1:0] rr_ptr, hi, lo, win;
  logic any;
  for (genvar i = 0; i < N_FU; i++) begin : g_slot
    fu_skid_slot #(.W(P_W)) u_slot (
      .clk(clk),
      .rst(rst),
      .in_valid(fu_valid[i]),
      .in_payload({fu_data[i*DATA_W +: DATA_W], fu_rob_idx[i*IDX_W +: IDX_W], fu_rd[i*RD_W +: RD_W]}),
      .grant(grant_oh[i]),
      .kill(kill[i]),
      .ready(fu_ready[i]),
      .cand_valid(cand_valid[i]),
      .cand_payload(cand_pl[i])
    );
    assign kill[i] = flush_valid && is_younger(16'(cand_pl[i][RD_W +: IDX_W]), 16'(flush_rob_idx),
                                               16'(rob_head), 16'(ROB_LEN - 1));
  end
  assign eligible = cand_valid & ~kill;
  assign masked = (ARB_MODE == ARB_RR) ? eligible & ~((N_FU'(1) << rr_ptr) - N_FU'(1)) : eligible;
  // two-pass priority encode: lowest index at or above the pointer, else lowest overall
  always_comb begin
    hi = '0;
    lo = '0;
    for (int k = N_FU - 1; k >= 0; k--) begin
      hi = masked[k] ? PW'(k) : hi;
      lo = eligible[k] ? PW'(k) : lo;
    end
  end
  assign any = |eligible;
  assign win = (|masked) ? hi : lo;
  assign grant_oh = any ? (N_FU'(1) << win) : '0;
  assign fwd_pl = any ? cand_pl[win] : '0;
  assign fwd_valid = any;
  assign {fwd_data, fwd_rob_idx, fwd_rd} = fwd_pl;
  // round-robin pointer moves past the winner on every grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr <= '0;
    else if (any) rr_ptr <= (win == PW'(N_FU - 1)) ? '0 : win + 1'b1;
  end
  // writeback stage is the forward bus delayed by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      {wb_data, wb_rob_idx, wb_rd} <= '0;
    end else begin
      wb_valid <= fwd_valid;
      {wb_data, wb_rob_idx, wb_rd} <= fwd_pl;
    end
  end
endmodule

// File: tb/tb_exe_result_arbiter.sv
// tb_exe_result_arbiter: directed checks of slot capture, arbitration, forwarding and age-based flush
module tb_exe_result_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] rob_head, flush_rob_idx;
  logic flush_valid;
  logic [7:0] fv_f, ready_f, grant_f, fv_r, ready_r, grant_r;
  logic [255:0] fd_f, fd_r;
  logic [31:0] fr_f, fr_r;
  logic [55:0] frd_f, frd_r;
  logic fwd_valid_f, wb_valid_f, fwd_valid_r, wb_valid_r;
  logic [31:0] fwd_data_f, wb_data_f, fwd_data_r, wb_data_r;
  logic [3:0] fwd_rob_f, wb_rob_f, fwd_rob_r, wb_rob_r;
  logic [6:0] fwd_rd_f, wb_rd_f, fwd_rd_r, wb_rd_r;
  int checks = 0, failures = 0, proto_err = 0, maxw = 0, ming = 0;
  int wt [8];
  int ng [8];
  bit pend [8];

  always #5 clk = ~clk;

  exe_result_arbiter #(.ARB_MODE(0)) dut_f (
    .clk(clk), .rst(rst), .fu_valid(fv_f), .fu_data(fd_f), .fu_rob_idx(fr_f), .fu_rd(frd_f),
    .fu_ready(ready_f), .rob_head(rob_head), .flush_valid(flush_valid), .flush_rob_idx(flush_rob_idx),
    .fwd_valid(fwd_valid_f), .fwd_data(fwd_data_f), .fwd_rob_idx(fwd_rob_f), .fwd_rd(fwd_rd_f),
    .wb_valid(wb_valid_f), .wb_data(wb_data_f), .wb_rob_idx(wb_rob_f), .wb_rd(wb_rd_f), .grant_oh(grant_f)
  );

  exe_result_arbiter #(.ARB_MODE(1)) dut_r (
    .clk(clk), .rst(rst), .fu_valid(fv_r), .fu_data(fd_r), .fu_rob_idx(fr_r), .fu_rd(frd_r),
    .fu_ready(ready_r), .rob_head(rob_head), .flush_valid(flush_valid), .flush_rob_idx(flush_rob_idx),
    .fwd_valid(fwd_valid_r), .fwd_data(fwd_data_r), .fwd_rob_idx(fwd_rob_r), .fwd_rd(fwd_rd_r),
    .wb_valid(wb_valid_r), .wb_data(wb_data_r), .wb_rob_idx(wb_rob_r), .wb_rd(wb_rd_r), .grant_oh(grant_r)
  );

  // producers must never present a result to a full slot
  always @(negedge clk) if (!rst && (((fv_f & ~ready_f) != '0) || ((fv_r & ~ready_r) != '0))) proto_err++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_f(input int ch, input logic [31:0] d, input logic [3:0] r, input logic [6:0] rd);
    fv_f[ch] = 1'b1;
    fd_f[ch*32 +: 32] = d;
    fr_f[ch*4 +: 4] = r;
    frd_f[ch*7 +: 7] = rd;
  endtask

  initial begin
    rst = 1'b1;
    {fv_f, fd_f, fr_f, frd_f, fv_r, fd_r, fr_r, frd_r} = '0;
    rob_head = '0;
    flush_valid = 1'b0;
    flush_rob_idx = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", 32'(ready_f), 32'hFF);
    chk("rst_wb_valid", 32'(wb_valid_f), 32'h0);
    chk("rst_fwd_valid", 32'(fwd_valid_f), 32'h0);
    chk("rst_wb_data", wb_data_f, 32'h0);
    set_f(0, 32'h11, 4'd1, 7'd1);
    set_f(2, 32'h22, 4'd2, 7'd2);
    fv_r[4] = 1'b1;
    settle();
    chk("t1_grant_a", 32'(grant_f), 32'h01);
    tick();
    fv_f = '0;
    fv_r = '0;
    settle();
    chk("t1_held_ready", 32'(ready_f), 32'hFB);
    chk("t1_grant_held", 32'(grant_f), 32'h04);
    chk("t1_wb_a", wb_data_f, 32'h11);
    chk("t1_rr_ptr_moved", 32'(dut_r.rr_ptr), 32'd5);
    rst = 1'b1;
    settle();
    chk("t1_async_ready", 32'(ready_f), 32'hFF);
    chk("t1_async_wb_valid", 32'(wb_valid_f), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("t1_post_ready", 32'(ready_f), 32'hFF);
    chk("t1_post_wb_valid", 32'(wb_valid_f), 32'h0);
    chk("t1_post_fwd_valid", 32'(fwd_valid_f), 32'h0);
    chk("t1_post_rr_ptr", 32'(dut_r.rr_ptr), 32'd0);
    set_f(0, 32'hDEADBEEF, 4'd3, 7'd5);
    settle();
    chk("t2_fwd_valid", 32'(fwd_valid_f), 32'h1);
    chk("t2_fwd_data", fwd_data_f, 32'hDEADBEEF);
    chk("t2_fwd_rob", 32'(fwd_rob_f), 32'd3);
    chk("t2_grant", 32'(grant_f), 32'h01);
    tick();
    fv_f = '0;
    settle();
    chk("t2_wb_valid", 32'(wb_valid_f), 32'h1);
    chk("t2_wb_data", wb_data_f, 32'hDEADBEEF);
    chk("t2_wb_rob", 32'(wb_rob_f), 32'd3);
    chk("t2_wb_rd", 32'(wb_rd_f), 32'd5);
    chk("t2_ready", 32'(ready_f), 32'hFF);
    chk("t2_fwd_idle", 32'(fwd_valid_f), 32'h0);
    set_f(1, 32'hA1, 4'd1, 7'd1);
    set_f(3, 32'hA3, 4'd3, 7'd3);
    set_f(6, 32'hA6, 4'd6, 7'd6);
    settle();
    chk("t3_grant_c0", 32'(grant_f), 32'h02);
    chk("t3_fwd_c0", fwd_data_f, 32'hA1);
    tick();
    fv_f = '0;
    settle();
    chk("t3_ready_c1", 32'(ready_f), 32'hB7);
    chk("t3_grant_c1", 32'(grant_f), 32'h08);
    chk("t3_fwd_c1", fwd_data_f, 32'hA3);
    chk("t3_wb_c1", wb_data_f, 32'hA1);
    tick();
    settle();
    chk("t3_ready_c2", 32'(ready_f), 32'hBF);
    chk("t3_grant_c2", 32'(grant_f), 32'h40);
    chk("t3_fwd_c2", fwd_data_f, 32'hA6);
    chk("t3_wb_c2", wb_data_f, 32'hA3);
    tick();
    settle();
    chk("t3_ready_c3", 32'(ready_f), 32'hFF);
    chk("t3_fwd_valid_c3", 32'(fwd_valid_f), 32'h0);
    chk("t3_wb_c3", wb_data_f, 32'hA6);
    chk("t3_wb_valid_c3", 32'(wb_valid_f), 32'h1);
    tick();
    settle();
    chk("t3_wb_valid_c4", 32'(wb_valid_f), 32'h0);
    rob_head = 4'd4;
    tick();
    set_f(0, 32'hB0, 4'd4, 7'd10);
    set_f(2, 32'hB5, 4'd5, 7'd11);
    set_f(4, 32'hB9, 4'd9, 7'd12);
    set_f(5, 32'hBC, 4'd12, 7'd13);
    settle();
    chk("t4_grant_blocker", 32'(grant_f), 32'h01);
    tick();
    fv_f = '0;
    settle();
    chk("t4_held_ready", 32'(ready_f), 32'hCB);
    flush_valid = 1'b1;
    flush_rob_idx = 4'd8;
    settle();
    chk("t4_flush_grant", 32'(grant_f), 32'h04);
    chk("t4_flush_fwd_rob", 32'(fwd_rob_f), 32'd5);
    chk("t4_flush_fwd_data", fwd_data_f, 32'hB5);
    tick();
    flush_valid = 1'b0;
    settle();
    chk("t4_ready_after", 32'(ready_f), 32'hFF);
    chk("t4_fwd_valid_after", 32'(fwd_valid_f), 32'h0);
    chk("t4_wb_rob", 32'(wb_rob_f), 32'd5);
    chk("t4_wb_valid", 32'(wb_valid_f), 32'h1);
    rob_head = 4'd14;
    flush_valid = 1'b1;
    flush_rob_idx = 4'd1;
    tick();
    set_f(1, 32'hC2, 4'd2, 7'd20);
    set_f(3, 32'hC0, 4'd0, 7'd21);
    settle();
    chk("t5_grant", 32'(grant_f), 32'h08);
    chk("t5_fwd_rob", 32'(fwd_rob_f), 32'd0);
    chk("t5_fwd_data", fwd_data_f, 32'hC0);
    tick();
    fv_f = '0;
    flush_valid = 1'b0;
    settle();
    chk("t5_ready", 32'(ready_f), 32'hFF);
    chk("t5_wb_valid", 32'(wb_valid_f), 32'h1);
    chk("t5_wb_rob", 32'(wb_rob_f), 32'd0);
    chk("t5_wb_data", wb_data_f, 32'hC0);
    rob_head = 4'd0;
    tick();
    set_f(0, 32'hD2, 4'd2, 7'd30);
    set_f(5, 32'hD7, 4'd7, 7'd31);
    settle();
    chk("t6_grant_blocker", 32'(grant_f), 32'h01);
    tick();
    fv_f = '0;
    settle();
    chk("t6_held_ready", 32'(ready_f), 32'hDF);
    chk("t6_grant_noflush", 32'(grant_f), 32'h20);
    flush_valid = 1'b1;
    flush_rob_idx = 4'd6;
    settle();
    chk("t6_grant_flush", 32'(grant_f), 32'h00);
    chk("t6_fwd_valid_flush", 32'(fwd_valid_f), 32'h0);
    tick();
    flush_valid = 1'b0;
    settle();
    chk("t6_ready", 32'(ready_f), 32'hFF);
    chk("t6_wb_valid", 32'(wb_valid_f), 32'h0);
    chk("t6_fwd_valid", 32'(fwd_valid_f), 32'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      wt[i] = 0;
      ng[i] = 0;
      pend[i] = 1'b0;
    end
    for (int c = 0; c < 48; c++) begin
      fv_r = ready_r;
      for (int i = 0; i < 8; i++) begin
        fd_r[i*32 +: 32] = 32'(c * 16 + i);
        fr_r[i*4 +: 4] = 4'(i);
        frd_r[i*7 +: 7] = 7'(i);
      end
      settle();
      chk("rr_onehot", 32'($onehot0(grant_r)), 32'h1);
      for (int i = 0; i < 8; i++) begin
        if (fv_r[i]) pend[i] = 1'b1;
        if (pend[i] && grant_r[i]) begin
          maxw = (wt[i] > maxw) ? wt[i] : maxw;
          ng[i]++;
          wt[i] = 0;
          pend[i] = 1'b0;
        end else if (pend[i]) wt[i]++;
      end
      tick();
    end
    fv_r = '0;
    ming = ng[0];
    for (int i = 1; i < 8; i++) ming = (ng[i] < ming) ? ng[i] : ming;
    chk("rr_max_wait_le_7", 32'(maxw <= 7), 32'h1);
    chk("rr_min_grants_ge_5", 32'(ming >= 5), 32'h1);
    chk("protocol", 32'(proto_err), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
